// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, legality check and datapath widths.
// Imported by the issue stage, the ALU and its reference model.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_t;

    function automatic logic is_legal_alu_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB over the default data.
// Register 0 always reads as zero.
module fwd_mux #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       dflt_data,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]       mwb_result,
    output logic [XLEN-1:0]       data,
    output logic                  hit
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = dflt_data;
        hit  = 1'b0;
        if (rs_addr == '0) begin
            data = '0;
        end else if (exm_reg_write && exm_rd == rs_addr) begin
            data = exm_result;
            hit  = 1'b1;
        end else if (mwb_reg_write && mwb_rd == rs_addr) begin
            data = mwb_result;
            hit  = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry registered issue stage in front of the ALU: valid/ready handshake,
// RAW forwarding with refresh while stalled, immediate select and illegal-op flag.
module alu_issue_stage #(
    parameter int XLEN       = alu_pkg::XLEN,
    parameter int REG_ADDR_W = alu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [3:0]            dec_alu_op,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
    input  logic [XLEN-1:0]       dec_rs1_data,
    input  logic [XLEN-1:0]       dec_rs2_data,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic                  dec_use_imm,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr,
    input  logic                  dec_reg_write,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]       mwb_result,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [3:0]            alu_op,
    output logic [XLEN-1:0]       in_a,
    output logic [XLEN-1:0]       in_b,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_illegal
);

    import alu_pkg::*;

    logic                  valid_q;
    // NOTE: opcode is held as raw bits, not alu_op_t, so illegal encodings pass through intact.
    logic [3:0]            op_q;
    logic [XLEN-1:0]       a_q, b_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic                  use_imm_q, reg_write_q, illegal_q;

    logic                  accept, stall;
    logic [REG_ADDR_W-1:0] rs1_sel, rs2_sel;
    logic [XLEN-1:0]       a_dflt, b_dflt, a_fwd, b_fwd;
    logic                  a_hit, b_hit;

    assign dec_ready = !valid_q || ex_ready;
    assign accept    = dec_valid && dec_ready && !flush;
    assign stall     = valid_q && !ex_ready;

    // On accept the muxes look at the incoming operand, otherwise at the held one.
    assign rs1_sel = accept ? dec_rs1_addr : rs1_q;
    assign rs2_sel = accept ? dec_rs2_addr : rs2_q;
    assign a_dflt  = accept ? dec_rs1_data : a_q;
    assign b_dflt  = accept ? dec_rs2_data : b_q;

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_addr       (rs1_sel),
        .dflt_data     (a_dflt),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (a_fwd),
        .hit           (a_hit)
    );

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_addr       (rs2_sel),
        .dflt_data     (b_dflt),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (b_fwd),
        .hit           (b_hit)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            op_q        <= dec_alu_op;
            a_q         <= a_fwd;
            b_q         <= dec_use_imm ? dec_imm : b_fwd;
            rs1_q       <= dec_rs1_addr;
            rs2_q       <= dec_rs2_addr;
            rd_q        <= dec_rd_addr;
            use_imm_q   <= dec_use_imm;
            reg_write_q <= dec_reg_write;
            illegal_q   <= !is_legal_alu_op(dec_alu_op);
        end else if (stall) begin
            // Capture a late producer now so the value outlives its forward window.
            if (a_hit) begin
                a_q <= a_fwd;
            end
            if (b_hit && !use_imm_q) begin
                b_q <= b_fwd;
            end
        end else if (valid_q && ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_op       = op_q;
    assign in_a         = a_q;
    assign in_b         = b_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, issue, forwarding, stall refresh,
// immediate/illegal handling and flush, all against hand-computed values.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, dec_valid, dec_ready;
    logic [3:0]  dec_alu_op;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
    logic        dec_use_imm, dec_reg_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        ex_ready, ex_valid, ex_reg_write, ex_illegal;
    logic [3:0]  alu_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  ex_rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_alu_op    (dec_alu_op),
        .dec_rs1_addr  (dec_rs1_addr),
        .dec_rs2_addr  (dec_rs2_addr),
        .dec_rs1_data  (dec_rs1_data),
        .dec_rs2_data  (dec_rs2_data),
        .dec_imm       (dec_imm),
        .dec_use_imm   (dec_use_imm),
        .dec_rd_addr   (dec_rd_addr),
        .dec_reg_write (dec_reg_write),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .alu_op        (alu_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_illegal    (ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs change only here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic use_imm,
                             input logic [31:0] imm, input logic [4:0] rd, input logic rw);
        dec_alu_op    = op;
        dec_rs1_addr  = rs1;
        dec_rs1_data  = d1;
        dec_rs2_addr  = rs2;
        dec_rs2_data  = d2;
        dec_use_imm   = use_imm;
        dec_imm       = imm;
        dec_rd_addr   = rd;
        dec_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exm_reg_write = ew;
        exm_rd        = erd;
        exm_result    = eres;
        mwb_reg_write = mw;
        mwb_rd        = mrd;
        mwb_result    = mres;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t b2b [3] = '{
        '{4'b0001, 32'h0000_0010, 32'h0000_0020},
        '{4'b0000, 32'h0000_0030, 32'h0000_0040},
        '{4'b0110, 32'hCAFE_0001, 32'h0BAD_0002}
    };

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        dec_valid = 1'b1;
        ex_ready  = 1'b1;
        set_instr(4'b0010, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 32'h0, 5'd3, 1'b1);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset held for two edges while decode offers an instruction.
        step();
        step();
        check("rst_valid",  {31'b0, ex_valid}, 32'h0);
        check("rst_in_a",   in_a, 32'h0);
        check("rst_in_b",   in_b, 32'h0);
        check("rst_op",     {28'b0, alu_op}, 32'h0);
        check("rst_rw",     {31'b0, ex_reg_write}, 32'h0);
        check("rst_illeg",  {31'b0, ex_illegal}, 32'h0);
        rst       = 1'b0;
        dec_valid = 1'b0;
        #1;
        check("rst_ready",  {31'b0, dec_ready}, 32'h1);

        // Basic ADD issue.
        dec_valid = 1'b1;
        set_instr(4'b0010, 5'd1, 32'h5, 5'd2, 32'h7, 1'b0, 32'h0, 5'd4, 1'b1);
        step();
        check("add_valid",  {31'b0, ex_valid}, 32'h1);
        check("add_op",     {28'b0, alu_op}, 32'h2);
        check("add_in_a",   in_a, 32'h5);
        check("add_in_b",   in_b, 32'h7);
        check("add_rd",     {27'b0, ex_rd_addr}, 32'h4);
        check("add_rw",     {31'b0, ex_reg_write}, 32'h1);

        // Back-to-back accepts with ex_ready=1: a new entry every cycle.
        for (int i = 0; i < 3; i++) begin
            set_instr(b2b[i].op, 5'd10, b2b[i].a, 5'd11, b2b[i].b, 1'b0, 32'h0, 5'd12, 1'b0);
            step();
            check("b2b_valid", {31'b0, ex_valid}, 32'h1);
            check("b2b_op",    {28'b0, alu_op}, {28'b0, b2b[i].op});
            check("b2b_in_a",  in_a, b2b[i].a);
            check("b2b_in_b",  in_b, b2b[i].b);
        end

        // EX/MEM wins over MEM/WB.
        set_instr(4'b0010, 5'd3, 32'h1, 5'd5, 32'h9, 1'b0, 32'h0, 5'd6, 1'b1);
        set_fwd(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd3, 32'h5555_5555);
        step();
        check("fwd_exm_a",  in_a, 32'hAAAA_AAAA);
        check("fwd_nohit_b", in_b, 32'h9);
        // MEM/WB alone.
        set_fwd(1'b0, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd3, 32'h5555_5555);
        step();
        check("fwd_mwb_a",  in_a, 32'h5555_5555);
        // rs1=0 reads zero even with sources targeting x0 and nonzero dec data.
        set_instr(4'b0010, 5'd0, 32'hDEAD_BEEF, 5'd5, 32'h9, 1'b0, 32'h0, 5'd6, 1'b1);
        set_fwd(1'b1, 5'd0, 32'hAAAA_AAAA, 1'b1, 5'd0, 32'h5555_5555);
        step();
        check("fwd_x0_a",   in_a, 32'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Stall with refresh of rs2 from MEM/WB in the second stalled cycle.
        set_instr(4'b0010, 5'd6, 32'h11, 5'd7, 32'h22, 1'b0, 32'h0, 5'd8, 1'b1);
        step();
        check("stl_in_b0",  in_b, 32'h22);
        ex_ready = 1'b0;
        set_instr(4'b0001, 5'd9, 32'h999, 5'd9, 32'h999, 1'b0, 32'h0, 5'd9, 1'b0);
        #1;
        check("stl_ready1", {31'b0, dec_ready}, 32'h0);
        step();
        check("stl_in_b1",  in_b, 32'h22);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        check("stl_ready2", {31'b0, dec_ready}, 32'h0);
        step();
        check("stl_refresh", in_b, 32'h1234);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("stl_ready3", {31'b0, dec_ready}, 32'h0);
        step();
        check("stl_keep_b", in_b, 32'h1234);
        check("stl_keep_a", in_a, 32'h11);
        check("stl_keep_op", {28'b0, alu_op}, 32'h2);
        check("stl_keep_v", {31'b0, ex_valid}, 32'h1);
        // Drain with no new instruction: entry retires.
        ex_ready  = 1'b1;
        dec_valid = 1'b0;
        step();
        check("drain_valid", {31'b0, ex_valid}, 32'h0);

        // SUB with immediate: rs2 forwarding ignored.
        dec_valid = 1'b1;
        set_instr(4'b0110, 5'd1, 32'h4, 5'd8, 32'h3, 1'b1, 32'hFFFF_FFFF, 5'd2, 1'b1);
        set_fwd(1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 32'h0);
        step();
        check("imm_in_b",   in_b, 32'hFFFF_FFFF);
        check("imm_op",     {28'b0, alu_op}, 32'h6);
        check("imm_illeg",  {31'b0, ex_illegal}, 32'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Illegal opcode still presented.
        set_instr(4'b1111, 5'd1, 32'h4, 5'd2, 32'h3, 1'b0, 32'h0, 5'd2, 1'b1);
        step();
        check("ill_flag",   {31'b0, ex_illegal}, 32'h1);
        check("ill_op",     {28'b0, alu_op}, 32'hF);
        check("ill_valid",  {31'b0, ex_valid}, 32'h1);

        // Flush during a stall with decode offering an instruction.
        set_instr(4'b0010, 5'd1, 32'h42, 5'd2, 32'h43, 1'b0, 32'h0, 5'd9, 1'b1);
        step();
        check("pre_flush_rw", {31'b0, ex_reg_write}, 32'h1);
        ex_ready = 1'b0;
        flush    = 1'b1;
        set_instr(4'b0001, 5'd1, 32'hBEEF, 5'd2, 32'hBEEF, 1'b0, 32'h0, 5'd7, 1'b1);
        #1;
        check("fl_ready",   {31'b0, dec_ready}, 32'h0);
        step();
        flush     = 1'b0;
        dec_valid = 1'b0;
        check("fl_valid",   {31'b0, ex_valid}, 32'h0);
        check("fl_rw",      {31'b0, ex_reg_write}, 32'h0);
        check("fl_no_cap",  {31'b0, (in_a == 32'hBEEF)}, 32'h0);
        #1;
        check("fl_ready2",  {31'b0, dec_ready}, 32'h1);
        // Flush with ex_ready=1 also blocks the accept.
        ex_ready  = 1'b1;
        dec_valid = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        check("fl2_valid",  {31'b0, ex_valid}, 32'h0);
        // Normal issue resumes afterwards.
        set_instr(4'b0000, 5'd4, 32'h0F0F, 5'd5, 32'h00FF, 1'b0, 32'h0, 5'd6, 1'b1);
        step();
        check("post_valid", {31'b0, ex_valid}, 32'h1);
        check("post_in_a",  in_a, 32'h0F0F);
        check("post_in_b",  in_b, 32'h00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the ALU. It takes decoded instructions from decode and holds them in a one-entry pipeline register with a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, selects register or immediate for in_b, and drives alu_op/in_a/in_b into the alu.
- Flags illegal ALU opcodes so they never reach the ALU silently.

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  kill the held entry (branch redirect).
- dec_valid  in  1  decode presents an instruction.
- dec_ready  out  1  stage can accept this cycle.
- dec_alu_op  in  4  ALU opcode.
- dec_rs1_addr, dec_rs2_addr  in  REG_ADDR_W  source indices.
- dec_rs1_data, dec_rs2_data  in  XLEN  register-file read data.
- dec_imm  in  XLEN  sign-extended immediate.
- dec_use_imm  in  1  in_b = immediate.
- dec_rd_addr  in  REG_ADDR_W  destination index, passed through.
- dec_reg_write  in  1  writes rd, passed through.
- exm_reg_write, exm_rd, exm_result  in  1/REG_ADDR_W/XLEN  EX/MEM forward source.
- mwb_reg_write, mwb_rd, mwb_result  in  1/REG_ADDR_W/XLEN  MEM/WB forward source.
- ex_ready  in  1  execute consumes the entry.
- ex_valid  out  1  entry held and valid.
- alu_op  out  4  to alu.alu_op.
- in_a, in_b  out  XLEN  to alu.in_a / alu.in_b.
- ex_rd_addr, ex_reg_write  out  REG_ADDR_W/1  passed through.
- ex_illegal  out  1  held alu_op not in {0000 AND, 0001 OR, 0010 ADD, 0110 SUB}.

Behaviour:
- Reset: all outputs and held state are 0 on the rising clk with rst=1. ex_valid=0, alu_op=0000, in_a=in_b=0, ex_rd_addr=0, ex_reg_write=0, ex_illegal=0.
- Handshake: dec_ready = !ex_valid || ex_ready, combinational.
  - Accept happens when dec_valid && dec_ready. Fields are captured on that edge, so outputs appear 1 cycle after accept.
  - If ex_valid && ex_ready && !accept, then ex_valid goes to 0 next cycle.
  - While ex_valid && !ex_ready, all outputs are held stable except for the forwarding refresh rule below.
- Forwarding, per operand, evaluated for the incoming operand on accept and for the held operand every stalled cycle:
  - Hit condition: src_reg_write && src_rd == rs_addr && rs_addr != 0.
  - Priority: EX/MEM over MEM/WB over register data or held value.
  - rs_addr == 0 always yields 0, regardless of forward sources or dec data.
  - Refresh: a hit while stalled overwrites the held operand on that edge, so the value survives the producer retiring.
- Operand B: if use_imm, in_b = imm and rs2 forwarding is ignored. use_imm and the rs addresses are held internally.
- ex_illegal is registered with the entry. The illegal op is still presented, so the ALU and its assertions see it.
- Flush:
  - flush=1 clears ex_valid and ex_reg_write next edge and blocks any same-cycle accept; dec_ready stays as defined.
  - Flush has priority over accept and over the stall.
  - rst has priority over flush.
- Reset or flush mid-stall: the entry is discarded and no partial state is retained.

Decomposition:
- alu_pkg: alu_op_t enum (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110), function is_legal_alu_op, and the XLEN/REG_ADDR_W constants, shared with the alu and its ref model.
- Sub-module fwd_mux, instantiated twice (rs1, rs2). It is combinational: it takes rs_addr, default data and the two forward sources, and returns the selected data plus a hit flag.

Test Plan:
- Reset: assert rst for 2 cycles with dec_valid=1 -> ex_valid=0, in_a=in_b=0, alu_op=0000, dec_ready=1 after release.
- Basic issue: accept ADD, rs1 data=0x5, rs2 data=0x7, ex_ready=1 -> next cycle ex_valid=1, alu_op=0010, in_a=5, in_b=7. Back-to-back accepts every cycle show no bubbles.
- Forward priority: rs1=3, exm_rd=3 result=0xAAAA_AAAA, mwb_rd=3 result=0x5555_5555, both reg_write -> in_a=0xAAAA_AAAA. Same setup with rs1=0 -> in_a=0.
- Stall plus refresh: hold ex_ready=0 for 3 cycles; in cycle 2 drive mwb_rd=rs2 with result 0x1234 -> in_b=0x1234 and stays 0x1234 after the source drops. dec_ready=0 throughout; no accept.
- Immediate and illegal: SUB with use_imm=1, imm=0xFFFF_FFFF, exm_rd=rs2 -> in_b=0xFFFF_FFFF. alu_op=4'b1111 -> ex_illegal=1 with op presented unchanged.
- Flush: flush with dec_valid=1 during a stall -> ex_valid=0 and ex_reg_write=0 next cycle, and the flushed instruction is not captured.
